spram512x32_req_ctrl: RTL
=========================

// Module: spram512x32_req_ctrl
// PURPOSE
//  Request front-end for the 512x32 byte-enable single-port SRAM wrapper (std_spram512x32).
//  Converts a valid/ready read/write request stream into active-low CEB/WEB/A/D/BE strobes.
//  Captures the 1-cycle-latency read data into a response FIFO so the consumer can apply backpressure.
//  Optionally zero-fills the array after reset before accepting any traffic.
// PARAMETERS
//  ADDR_W      9   SRAM address width; DEPTH = 2**ADDR_W
//  DATA_W      32  data width; byte lanes = DATA_W/8
//  RSP_DEPTH   4   response FIFO entries; must be >=2; >=3 sustains 1 read/cycle
//  INIT_ZERO   1   1: zero-fill all DEPTH words after reset; 0: go straight to RUN
// PORTS
//  clk        in   1       single clock, also drives the SRAM wrapper CLK
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       request accepted this cycle when valid&ready
//  req_we     in   1       1=write, 0=read
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  write data
//  req_be     in   DATA_W/8  byte enables, write only
//  rsp_valid  out  1       read data available
//  rsp_ready  in   1       consumer takes rsp_rdata when valid&ready
//  rsp_rdata  out  DATA_W  read data, in request order
//  init_done  out  1       1 once zero-fill finished (or immediately if INIT_ZERO=0)
//  mem_ceb    out  1       SRAM chip enable, active low
//  mem_web    out  1       SRAM write enable, active low
//  mem_a      out  ADDR_W  SRAM address
//  mem_d      out  DATA_W  SRAM write data
//  mem_be     out  DATA_W/8  SRAM byte enables, active high
//  mem_q      in   DATA_W  SRAM read data, valid the cycle after a read strobe
// BEHAVIOUR
//  - FSM states are INIT and RUN.
//    - rst=1 forces INIT if INIT_ZERO=1, else RUN. It also clears init_cnt, rd_pend and the FIFO.
//    - INIT -> RUN after the write to address DEPTH-1.
//  - While rst=1, outputs are forced: mem_ceb=1, mem_web=1, req_ready=0, rsp_valid=0. init_done resets to 0 (1 if INIT_ZERO=0).
//  - INIT behaviour:
//    - Every cycle: mem_ceb=0, mem_web=0, mem_be=all-1, mem_d=0, mem_a=init_cnt, then init_cnt++.
//    - The fill takes exactly DEPTH cycles, and req_ready=0 throughout.
//    - init_done registers to 1 in the cycle after the last fill write and stays 1 until rst.
//  - RUN, credit:
//    - req_ready = (rd_pend + fifo_cnt) < RSP_DEPTH.
//    - Pops in the same cycle are NOT counted. Writes gate on credit too.
//  - RUN, accept (req_valid & req_ready):
//    - The strobes are combinational in the same cycle: mem_ceb=0, mem_web=~req_we, mem_a=req_addr, mem_d=req_wdata.
//    - mem_be=req_be for writes, all-1 for reads.
//    - A write with req_be=0 is still accepted and strobed; no byte changes.
//  - RUN, no accept: mem_ceb=1, mem_web=1. a/d/be hold last value (don't-care).
//  - Read path:
//    - An accepted read sets rd_pend=1 for the next cycle.
//    - In that cycle mem_q is pushed into the FIFO.
//    - rsp_valid rises 2 cycles after acceptance.
//    - The credit rule guarantees the push never overflows.
//  - Ordering: one port, strictly in order. A read after a write to the same address, accepted in a later cycle, returns the new data.
//  - Response FIFO:
//    - rsp_rdata is the FIFO head and is held stable while rsp_valid & ~rsp_ready.
//    - Push and pop in the same cycle are both legal, including push on empty (no bypass) and pop on full.
//  - Reset mid-operation: in-flight read data and buffered responses are discarded. No rsp is ever produced for them.
//  - Throughput: 1 req/cycle for any mix when rsp_ready=1 and RSP_DEPTH>=3. With RSP_DEPTH=2, reads run at 2 per 3 cycles.
// STRUCTURE
//  - Package spram_ctrl_pkg holds:
//    - the state enum {ST_INIT, ST_RUN};
//    - localparams SPRAM_ADDR_W=9, SPRAM_DATA_W=32, SPRAM_BE_W=4;
//    - the request struct type {we, addr, wdata, be}.
//  - One sub-module, spram_rsp_fifo:
//    - a synchronous FIFO of width DATA_W and depth RSP_DEPTH;
//    - ports push/pop/full/empty/count;
//    - sync active-high reset.
//  - FSM, init counter, credit logic and strobe muxing live in the top level.
// TESTING
//  - Reset, INIT_ZERO=1:
//    - exactly 512 write strobes, mem_a 0..511, with mem_d=0 and be=F;
//    - then init_done=1, and req_ready=0 throughout.
//  - Write/read:
//    - write 0x1A5 <- 0xDEADBEEF, be=F; then read 0x1A5;
//    - expect rsp_rdata=0xDEADBEEF with rsp_valid 2 cycles after the read accept.
//  - Byte enables:
//    - write 0x010 <- 0x11223344 (be=F), then write 0x010 <- 0xAABBCCDD (be=0101b);
//    - a read returns 0x11BB33DD.
//  - Backpressure:
//    - hold rsp_ready=0 and issue 6 reads (RSP_DEPTH=4);
//    - expect 4 accepts, then req_ready=0;
//    - release and check the 4 responses come out in order, with no loss or duplicates.
//  - Streaming:
//    - rsp_ready=1 with 100 back-to-back reads;
//    - expect one read strobe per cycle and 100 in-order responses.
//  - Mid-op reset:
//    - assert rst for 1 cycle with 2 responses buffered and 1 read in flight;
//    - expect rsp_valid=0 and no stale data, and INIT restarts at address 0.

Source files
------------

// File: rtl/spram512x32_req_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spram_ctrl_pkg
// Description : Shared types and sizes for the 512x32 SRAM request front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package spram_ctrl_pkg;

    localparam int SPRAM_ADDR_W = 9;
    localparam int SPRAM_DATA_W = 32;
    localparam int SPRAM_BE_W   = 4;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                    we;
        logic [SPRAM_ADDR_W-1:0] addr;
        logic [SPRAM_DATA_W-1:0] wdata;
        logic [SPRAM_BE_W-1:0]   be;
    } spram_req_t;

endpackage
`default_nettype wire

// File: rtl/spram512x32_req_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : spram512x32_req_ctrl_if
// Description : Request/response handshake bundle between a client and the
//               SRAM request controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface spram512x32_req_ctrl_if
    import spram_ctrl_pkg::*;
#(
    parameter int ADDR_W = SPRAM_ADDR_W,
    parameter int DATA_W = SPRAM_DATA_W
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/spram512x32_req_ctrl_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spram_rsp_fifo
// Description : Synchronous response FIFO; head is presented combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module spram_rsp_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_do_push;
    logic              w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == c_FULL_CNT);
    assign count     = r_cnt;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so push on full is legal then.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end
endmodule
`default_nettype wire

// File: rtl/spram512x32_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spram512x32_req_ctrl
// Description : Valid/ready request front-end for a 512x32 byte-enable SRAM,
//               with optional post-reset zero-fill and buffered read data.
// Revision    : 1.0 - initial release
// ============================================================================
module spram512x32_req_ctrl
    import spram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = SPRAM_ADDR_W,
    parameter int DATA_W    = SPRAM_DATA_W,
    parameter int RSP_DEPTH = 4,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    spram512x32_req_ctrl_if.slave   bus,
    output logic                    init_done,
    output logic                    mem_ceb,
    output logic                    mem_web,
    output logic [ADDR_W-1:0]       mem_a,
    output logic [DATA_W-1:0]       mem_d,
    output logic [DATA_W/8-1:0]     mem_be,
    input  logic [DATA_W-1:0]       mem_q
);
    localparam int c_BE_W  = DATA_W / 8;
    localparam int c_CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_W-1:0] c_ADDR_LAST = '1;
    localparam logic [c_CNT_W:0]  c_CREDITS   = (c_CNT_W + 1)'(RSP_DEPTH);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_init_cnt;
    logic                r_rd_pend;
    logic                r_init_done;
    logic [ADDR_W-1:0]   r_hold_a;
    logic [DATA_W-1:0]   r_hold_d;
    logic [c_BE_W-1:0]   r_hold_be;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_CNT_W-1:0]  w_fifo_cnt;
    logic [c_CNT_W:0]    w_outstanding;
    logic                w_run;
    logic                w_init_wr;
    logic                w_accept;
    logic                w_pop;

    // Credit counts the read in flight plus buffered entries; same-cycle pops
    // are deliberately ignored to keep ready off the pop path.
    assign w_outstanding = {1'b0, w_fifo_cnt} + {{c_CNT_W{1'b0}}, r_rd_pend};
    assign w_run         = ~rst & (r_state == ST_RUN);
    assign w_init_wr     = ~rst & (r_state == ST_INIT);
    assign bus.req_ready = w_run & ~w_fifo_full & (w_outstanding < c_CREDITS);
    assign w_accept      = bus.req_valid & bus.req_ready;
    assign bus.rsp_valid = ~rst & ~w_fifo_empty;
    assign w_pop         = bus.rsp_valid & bus.rsp_ready;
    assign init_done     = r_init_done;

    always_comb begin
        mem_ceb = 1'b1;
        mem_web = 1'b1;
        mem_a   = r_hold_a;
        mem_d   = r_hold_d;
        mem_be  = r_hold_be;
        if (w_init_wr) begin
            mem_ceb = 1'b0;
            mem_web = 1'b0;
            mem_a   = r_init_cnt;
            mem_d   = '0;
            mem_be  = '1;
        end else if (w_accept) begin
            mem_ceb = 1'b0;
            mem_web = ~bus.req_we;
            mem_a   = bus.req_addr;
            mem_d   = bus.req_wdata;
            mem_be  = bus.req_we ? bus.req_be : '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT_ZERO ? ST_INIT : ST_RUN;
            r_init_cnt  <= '0;
            r_rd_pend   <= 1'b0;
            r_init_done <= ~INIT_ZERO;
        end else begin
            r_rd_pend <= w_accept & ~bus.req_we;
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + ADDR_W'(1);
                    if (r_init_cnt == c_ADDR_LAST) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Address/data/byte-enable keep their last driven value while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_a  <= '0;
            r_hold_d  <= '0;
            r_hold_be <= '0;
        end else if (!mem_ceb) begin
            r_hold_a  <= mem_a;
            r_hold_d  <= mem_d;
            r_hold_be <= mem_be;
        end
    end

    spram_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_rd_pend),
        .push_data (mem_q),
        .pop       (w_pop),
        .pop_data  (bus.rsp_rdata),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_cnt)
    );
endmodule
`default_nettype wire
